// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared state encoding and mux select constants for the round-robin arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/consumer bundle for the arbiter (lock signal only with MUX_ARB_LOCK_EN)
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;

  modport master (
    output req_a, req_b, data_a, data_b, lock,
    input  gnt_a, gnt_b, sel, out_valid, out_data
  );

  modport slave (
    input  req_a, req_b, data_a, data_b, lock,
    output gnt_a, gnt_b, sel, out_valid, out_data
  );
`else
  modport master (
    output req_a, req_b, data_a, data_b,
    input  gnt_a, gnt_b, sel, out_valid, out_data
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output gnt_a, gnt_b, sel, out_valid, out_data
  );
`endif

endinterface

// File: rtl/mux_rr_arbiter_mux_word.sv
// rtl/mux_rr_arbiter_mux_word.sv - word-wide 2:1 mux assembled from single-bit mux cells
module mux_bit (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic out
);

  assign out = sel ? b : a;

endmodule

module mux_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_bit u_bit (
      .a   (a[i]),
      .b   (b[i]),
      .sel (sel),
      .out (out[i])
    );
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin grant FSM with bounded hold driving a 2:1 data mux (optional lock: MUX_ARB_LOCK_EN)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] hold_stay;
  logic          last_q, last_d;
  logic          lock_hold;
  logic          sel;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = bus.lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Count used when the owner keeps the channel: wraps at the limit, or pins there while locked
  assign hold_stay = (hold_q == HOLD_LAST) ? (lock_hold ? HOLD_LAST : '0) : hold_q + HW'(1);

  // Next-state selection: tie-break on last owner, release on drop, rotate when the hold limit is hit
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) state_d = (last_q == SEL_B) ? GNT_A : GNT_B;
        else if (bus.req_a)         state_d = GNT_A;
        else if (bus.req_b)         state_d = GNT_B;
      end
      GNT_A: begin
        if (!bus.req_a)                                          state_d = bus.req_b ? GNT_B : IDLE;
        else if (bus.req_b && hold_q == HOLD_LAST && !lock_hold) state_d = GNT_B;
        else                                                     hold_d  = hold_stay;
      end
      GNT_B: begin
        if (!bus.req_b)                                          state_d = bus.req_a ? GNT_A : IDLE;
        else if (bus.req_a && hold_q == HOLD_LAST && !lock_hold) state_d = GNT_A;
        else                                                     hold_d  = hold_stay;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == GNT_A)      last_d = SEL_A;
      else if (state_d == GNT_B) last_d = SEL_B;
    end
  end

  // State, hold count and last-owner registers; B is treated as last owner out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= SEL_B;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign sel           = (state_q == GNT_B) ? SEL_B : SEL_A;
  assign bus.sel       = sel;
  assign bus.gnt_a     = (state_q == GNT_A);
  assign bus.gnt_b     = (state_q == GNT_B);
  assign bus.out_valid = (state_q == GNT_A) || (state_q == GNT_B);

  mux_word #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a   (bus.data_a),
    .b   (bus.data_b),
    .sel (sel),
    .out (bus.out_data)
  );

endmodule
